// File: rtl/gb_int_pkg.sv
// Shared constants for the GBC interrupt controller: IO register addresses,
// source bit positions and the request FSM states.
package gb_int_pkg;
  localparam logic [15:0] IF_ADDR = 16'hFF0F;
  localparam logic [15:0] IE_ADDR = 16'hFFFF;

  localparam int NUM_SRC = 5;
  localparam int VBLANK  = 0;
  localparam int LCDSTAT = 1;
  localparam int TIMER   = 2;
  localparam int SERIAL  = 3;
  localparam int JOYPAD  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } int_state_e;
endpackage

// File: rtl/int_priority_enc.sv
// Fixed-priority encoder: lowest set bit of the active mask wins (VBlank first).
// Purely combinational; vld_o is low when no bit is set.
module int_priority_enc (
  input  logic [4:0] active_i,
  output logic [2:0] idx_o,
  output logic       vld_o
);
  always_comb begin
    idx_o = 3'd0;
    vld_o = 1'b0;
    // Scan from the top so the lowest set index is the last one written.
    for (int i = 4; i >= 0; i--) begin
      if (active_i[i]) begin
        idx_o = 3'(i);
        vld_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/interrupt_controller.sv
// GBC interrupt controller: IF/IE registers on the IO bus, edge-latched sources,
// one prioritised request + vector to the CPU. Macro INTC_PENDING_OUT_EN enables O_INT_PENDING.
module interrupt_controller #(
  parameter int          NUM_SRC  = gb_int_pkg::NUM_SRC,
  parameter logic [15:0] VEC_BASE = 16'h0040
) (
  input  logic        I_CLOCK,
  input  logic        I_RESET,
  input  logic [15:0] I_ADDR,
  inout  wire  [7:0]  IO_DATA,
  input  logic        I_RE_L,
  input  logic        I_WE_L,
  input  logic        I_VBLANK_INT,
  input  logic        I_LCDSTAT_INT,
  input  logic        I_TIMER_INT,
  input  logic        I_SERIAL_INT,
  input  logic        I_JOYPAD_INT,
  input  logic        I_IME,
  input  logic        I_INT_ACK,
  output logic        O_INT_REQ,
  output logic [15:0] O_INT_VECTOR,
  output logic        O_INT_PENDING
);
  import gb_int_pkg::*;

  logic [NUM_SRC-1:0] src_now, src_q, if_q, if_d, edge_set, ack_clr, active;
  logic [7:0]         ie_q, ie_d, rd_dat;
  logic               wr_if, wr_ie, rd_hit;
  int_state_e         state_q, state_d;
  logic [2:0]         idx_q, idx_d, win_idx;
  logic               win_vld;
  logic [15:0]        vec_q, vec_d;
  logic               req_q, req_d;

  assign src_now[VBLANK]  = I_VBLANK_INT;
  assign src_now[LCDSTAT] = I_LCDSTAT_INT;
  assign src_now[TIMER]   = I_TIMER_INT;
  assign src_now[SERIAL]  = I_SERIAL_INT;
  assign src_now[JOYPAD]  = I_JOYPAD_INT;

  assign wr_if    = !I_WE_L && (I_ADDR == IF_ADDR);
  assign wr_ie    = !I_WE_L && (I_ADDR == IE_ADDR);
  assign edge_set = src_now & ~src_q;
  assign active   = if_q & ie_q[NUM_SRC-1:0];

  always_comb begin
    ack_clr = '0;
    if (state_q == REQ && I_INT_ACK) ack_clr[idx_q] = 1'b1;
  end

  // Precedence per bit: source edge over ack clear over bus write.
  assign if_d = ((wr_if ? IO_DATA[NUM_SRC-1:0] : if_q) & ~ack_clr) | edge_set;
  assign ie_d = wr_ie ? IO_DATA : ie_q;

  int_priority_enc u_enc (
    .active_i (active),
    .idx_o    (win_idx),
    .vld_o    (win_vld)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    req_d   = req_q;
    case (state_q)
      IDLE: begin
        if (win_vld && I_IME) begin
          idx_d   = win_idx;
          vec_d   = VEC_BASE + {10'd0, win_idx, 3'b000};
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // Vector stays frozen until ack or cancel, even if a higher source arrives.
        if (I_INT_ACK || !I_IME || !active[idx_q]) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      src_q   <= '0;
      if_q    <= '0;
      ie_q    <= 8'h00;
      state_q <= IDLE;
      idx_q   <= 3'd0;
      vec_q   <= 16'h0000;
      req_q   <= 1'b0;
    end else begin
      src_q   <= src_now;
      if_q    <= if_d;
      ie_q    <= ie_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      req_q   <= req_d;
    end
  end

  assign O_INT_REQ    = req_q;
  assign O_INT_VECTOR = vec_q;

`ifdef INTC_PENDING_OUT_EN
  logic pend_q;
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) pend_q <= 1'b0;
    else         pend_q <= |active;
  end
  assign O_INT_PENDING = pend_q;
`else
  assign O_INT_PENDING = 1'b0;
`endif

  always_comb begin
    rd_hit = 1'b0;
    rd_dat = ie_q;
    if (!I_RESET && !I_RE_L) begin
      if (I_ADDR == IF_ADDR) begin
        rd_hit = 1'b1;
        rd_dat = {3'b111, if_q};
      end else if (I_ADDR == IE_ADDR) begin
        rd_hit = 1'b1;
      end
    end
  end

  assign IO_DATA = rd_hit ? rd_dat : 8'hzz;
endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed vector table, hand-written corner
// sequences and randomized traffic checked against a behavioural model.
module tb_interrupt_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr_r = 16'h0000;
  logic        re_l = 1'b1, we_l = 1'b1;
  logic        vb = 0, lcd = 0, tim = 0, ser = 0, joy = 0;
  logic        ime_r = 0, ack_r = 0;
  logic        req_o, pend_o;
  logic [15:0] vec_o;
  logic        tb_drv = 1'b0;
  logic [7:0]  tb_dat = 8'h00;
  wire  [7:0]  io_data;

  assign io_data = tb_drv ? tb_dat : 8'hzz;

  always #5 clk = ~clk;

  interrupt_controller dut (
    .I_CLOCK(clk), .I_RESET(rst), .I_ADDR(addr_r), .IO_DATA(io_data),
    .I_RE_L(re_l), .I_WE_L(we_l),
    .I_VBLANK_INT(vb), .I_LCDSTAT_INT(lcd), .I_TIMER_INT(tim),
    .I_SERIAL_INT(ser), .I_JOYPAD_INT(joy),
    .I_IME(ime_r), .I_INT_ACK(ack_r),
    .O_INT_REQ(req_o), .O_INT_VECTOR(vec_o), .O_INT_PENDING(pend_o)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  logic [4:0]  m_if = 0, m_prev = 0;
  logic [7:0]  m_ie = 0;
  logic        m_req = 0, m_pend = 0;
  int          m_idx = 0;
  logic [15:0] m_vec = 0;

  logic exp_pend_hold;

  typedef struct {
    logic [4:0]  src;
    logic        ime;
    logic        ack;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  dat;
    logic        exp_req;
    logic [15:0] exp_vec;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [4:0] src, input logic ime, input logic ack,
                            input logic we, input logic [15:0] a, input logic [7:0] d);
    logic [4:0] nif, act;
    int first;
    act = m_if & m_ie[4:0];
    nif = m_if;
    if (we && a == 16'hFF0F) nif = d[4:0];
    if (we && a == 16'hFFFF) m_ie = d;
    if (m_req && ack) nif[m_idx] = 1'b0;
    for (int i = 0; i < 5; i++) if (src[i] && !m_prev[i]) nif[i] = 1'b1;
    first = -1;
    for (int i = 4; i >= 0; i--) if (act[i]) first = i;
    if (!m_req) begin
      if (first >= 0 && ime) begin
        m_idx = first;
        m_vec = 16'h0040 + 16'(8 * first);
        m_req = 1'b1;
      end
    end else if (ack) begin
      m_req = 1'b0;
    end else if (!ime || !act[m_idx]) begin
      m_req = 1'b0;
    end
`ifdef INTC_PENDING_OUT_EN
    m_pend = (act != 0);
`else
    m_pend = 1'b0;
`endif
    m_if   = nif;
    m_prev = src;
  endtask

  task automatic cyc(input logic [4:0] src, input logic ime, input logic ack,
                     input logic we, input logic [15:0] a, input logic [7:0] d);
    {joy, ser, tim, lcd, vb} = src;
    ime_r  = ime;
    ack_r  = ack;
    we_l   = !we;
    re_l   = 1'b1;
    addr_r = a;
    tb_dat = d;
    tb_drv = we;
    model_step(src, ime, ack, we, a, d);
    @(posedge clk);
    #1;
    ack_r  = 1'b0;
    we_l   = 1'b1;
    tb_drv = 1'b0;
    chk("model_req", {31'd0, req_o}, {31'd0, m_req});
    chk("model_vec", {16'd0, vec_o}, {16'd0, m_vec});
    chk("model_pend", {31'd0, pend_o}, {31'd0, m_pend});
  endtask

  task automatic rd(input string nm, input logic [15:0] a, input logic [7:0] exp);
    addr_r = a;
    we_l   = 1'b1;
    tb_drv = 1'b0;
    re_l   = 1'b0;
    #1;
    chk(nm, {24'd0, io_data}, {24'd0, exp});
    re_l = 1'b1;
    #1;
  endtask

  initial begin
`ifdef INTC_PENDING_OUT_EN
    exp_pend_hold = 1'b1;
`else
    exp_pend_hold = 1'b0;
`endif
    //           src    ime ack we addr      dat    req  vec
    tbl[0] = '{5'h00, 1, 0, 1, 16'hFFFF, 8'h04, 0, 16'h0000};
    tbl[1] = '{5'h04, 1, 0, 0, 16'h0000, 8'h00, 0, 16'h0000};
    tbl[2] = '{5'h04, 1, 0, 0, 16'h0000, 8'h00, 1, 16'h0050};
    tbl[3] = '{5'h00, 1, 0, 0, 16'h0000, 8'h00, 1, 16'h0050};
    tbl[4] = '{5'h00, 1, 1, 0, 16'h0000, 8'h00, 0, 16'h0050};
    tbl[5] = '{5'h00, 1, 0, 0, 16'h0000, 8'h00, 0, 16'h0050};

    // Reset state, and no bus drive from the DUT while reset is asserted
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, req_o}, 32'd0);
    chk("rst_vec", {16'd0, vec_o}, 32'd0);
    chk("rst_pend", {31'd0, pend_o}, 32'd0);
    addr_r = 16'hFF0F; re_l = 1'b0; tb_drv = 1'b1; tb_dat = 8'h5A;
    #1;
    chk("rst_bus_z", {24'd0, io_data}, 32'h5A);
    re_l = 1'b1; tb_drv = 1'b0;
    rst = 1'b0;
    #1;
    rd("rd_if_rst", 16'hFF0F, 8'hE0);
    rd("rd_ie_rst", 16'hFFFF, 8'h00);
    addr_r = 16'hFF0F; tb_drv = 1'b1; tb_dat = 8'h5A;
    #1;
    chk("idle_bus_z", {24'd0, io_data}, 32'h5A);
    tb_drv = 1'b0;

    // Timer request through the vector table
    for (int i = 0; i < 6; i++) begin
      cyc(tbl[i].src, tbl[i].ime, tbl[i].ack, tbl[i].we, tbl[i].addr, tbl[i].dat);
      chk($sformatf("tbl%0d_req", i), {31'd0, req_o}, {31'd0, tbl[i].exp_req});
      chk($sformatf("tbl%0d_vec", i), {16'd0, vec_o}, {16'd0, tbl[i].exp_vec});
    end
    rd("tbl_if_after_ack", 16'hFF0F, 8'hE0);

    // VBlank and joypad together: VBlank first, then joypad
    cyc(5'h00, 1, 0, 1, 16'hFFFF, 8'h1F);
    cyc(5'h11, 1, 0, 0, 16'h0000, 8'h00);
    cyc(5'h00, 1, 0, 0, 16'h0000, 8'h00);
    chk("two_vec_vblank", {16'd0, vec_o}, 32'h0040);
    cyc(5'h00, 1, 1, 0, 16'h0000, 8'h00);
    cyc(5'h00, 1, 0, 0, 16'h0000, 8'h00);
    chk("two_req_joy", {31'd0, req_o}, 32'd1);
    chk("two_vec_joy", {16'd0, vec_o}, 32'h0060);
    cyc(5'h00, 1, 1, 0, 16'h0000, 8'h00);
    rd("two_if_clear", 16'hFF0F, 8'hE0);

    // Higher-priority arrival while timer request is held
    cyc(5'h04, 1, 0, 0, 16'h0000, 8'h00);
    cyc(5'h00, 1, 0, 0, 16'h0000, 8'h00);
    cyc(5'h01, 1, 0, 0, 16'h0000, 8'h00);
    chk("hold_vec_a", {16'd0, vec_o}, 32'h0050);
    cyc(5'h00, 1, 0, 0, 16'h0000, 8'h00);
    chk("hold_vec_b", {16'd0, vec_o}, 32'h0050);
    cyc(5'h00, 1, 1, 0, 16'h0000, 8'h00);
    chk("hold_req_drop", {31'd0, req_o}, 32'd0);
    cyc(5'h00, 1, 0, 0, 16'h0000, 8'h00);
    chk("hold_vec_next", {16'd0, vec_o}, 32'h0040);
    cyc(5'h00, 1, 1, 0, 16'h0000, 8'h00);
    cyc(5'h00, 1, 0, 0, 16'h0000, 8'h00);

    // Edge beats a same-cycle write of zero to IF
    cyc(5'h04, 0, 0, 1, 16'hFF0F, 8'h00);
    rd("edge_vs_write", 16'hFF0F, 8'hE4);
    cyc(5'h00, 0, 0, 1, 16'hFF0F, 8'h00);

    // Dropping IME cancels the request and leaves IF alone
    cyc(5'h04, 1, 0, 0, 16'h0000, 8'h00);
    cyc(5'h00, 1, 0, 0, 16'h0000, 8'h00);
    chk("cancel_req_up", {31'd0, req_o}, 32'd1);
    cyc(5'h00, 0, 0, 0, 16'h0000, 8'h00);
    chk("cancel_req_down", {31'd0, req_o}, 32'd0);
    chk("cancel_pend", {31'd0, pend_o}, {31'd0, exp_pend_hold});
    rd("cancel_if_kept", 16'hFF0F, 8'hE4);
    cyc(5'h00, 0, 0, 1, 16'hFF0F, 8'h00);
    cyc(5'h00, 0, 0, 0, 16'h0000, 8'h00);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [4:0]  s;
      logic        im, ak, w;
      logic [15:0] a;
      logic [7:0]  d;
      s  = 5'($urandom) & 5'($urandom);
      im = ($urandom_range(0, 7) != 0);
      ak = m_req ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
      w  = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0: a = 16'hFF10;
        1: a = 16'hFFFF;
        default: a = 16'hFF0F;
      endcase
      d = 8'($urandom);
      cyc(s, im, ak, w, a, d);
      if (n % 4 == 0) begin
        if ($urandom_range(0, 1) == 1) rd("rnd_rd_if", 16'hFF0F, {3'b111, m_if});
        else rd("rnd_rd_ie", 16'hFFFF, m_ie);
      end
    end

    // Reset in the middle of a request aborts it at once
    cyc(5'h00, 0, 0, 1, 16'hFFFF, 8'h1F);
    cyc(5'h00, 0, 0, 1, 16'hFF0F, 8'h00);
    cyc(5'h04, 1, 0, 0, 16'h0000, 8'h00);
    cyc(5'h00, 1, 0, 0, 16'h0000, 8'h00);
    chk("midreq_up", {31'd0, req_o}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midreq_rst_req", {31'd0, req_o}, 32'd0);
    chk("midreq_rst_vec", {16'd0, vec_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Consumer of the timer's O_TIMER_INTERRUPT and the other GBC interrupt sources (VBlank, LCD STAT, serial, joypad).
- Latches rising edges into IF (0xFF0F) and masks them with IE (0xFFFF), both on the shared memory-mapped IO bus.
- Presents one prioritised request plus a restart vector to the CPU, and clears the serviced IF bit on the CPU acknowledge handshake.

Parameters:
- NUM_SRC, 5, number of interrupt sources (IF/IE bits [NUM_SRC-1:0]; fixed at 5 for GBC).
- VEC_BASE, 16'h0040, vector of source 0; source n vector = VEC_BASE + 8*n.

Ports:
- I_CLOCK  input  1  system clock; all state updates on its rising edge.
- I_RESET  input  1  asynchronous, active-high reset.
- I_ADDR  input  16  IO bus address.
- IO_DATA  inout  8  IO bus data; driven only during a matching read, otherwise high-Z.
- I_RE_L  input  1  active-low read enable.
- I_WE_L  input  1  active-low write enable.
- I_VBLANK_INT  input  1  source 0, priority highest.
- I_LCDSTAT_INT  input  1  source 1.
- I_TIMER_INT  input  1  source 2, from timer O_TIMER_INTERRUPT.
- I_SERIAL_INT  input  1  source 3.
- I_JOYPAD_INT  input  1  source 4, priority lowest.
- I_IME  input  1  CPU master interrupt enable.
- I_INT_ACK  input  1  one-cycle CPU acknowledge of the presented request.
- O_INT_REQ  output  1  request to CPU.
- O_INT_VECTOR  output  16  restart address for the presented request.
- O_INT_PENDING  output  1  (IF & IE) != 0, ignoring IME; used for HALT wake.

Behaviour:
- Reset (async, I_RESET high): IF=5'h00, IE=8'h00, edge-detect history=0, FSM=IDLE, O_INT_REQ=0, O_INT_VECTOR=16'h0000, O_INT_PENDING=0. IO_DATA is high-Z while reset is asserted.
- Edge detect: each source is registered every cycle. A rising edge (current=1, previous=0) sets the IF bit at that clock edge. Level held high sets it only once.
- Bus write (I_WE_L=0, sampled at the clock edge):
  - 0xFF0F loads IF <= IO_DATA[4:0].
  - 0xFFFF loads IE <= IO_DATA[7:0]; all 8 bits are stored and bits [7:5] are unused.
- Bus read (I_RE_L=0, combinational):
  - 0xFF0F drives {3'b111, IF}.
  - 0xFFFF drives IE.
  - Any other address leaves IO_DATA high-Z.
- Simultaneous events on the same IF bit in one cycle, highest precedence first:
  - source edge (sets the bit);
  - ack clear;
  - bus write.
  - Bits not touched by an edge or ack take the bus-write value.
- Priority: active = IF & IE[4:0]; the lowest-index set bit wins.
- FSM (registered outputs):
  - IDLE: if active != 0 and I_IME=1, latch winner index and vector; O_INT_REQ=1 from the next cycle; go REQ.
  - REQ: O_INT_REQ=1 and O_INT_VECTOR held stable even if a higher-priority bit arrives.
    - I_INT_ACK=1: clear IF[latched index], O_INT_REQ=0, go IDLE.
    - Else, if I_IME=0 or latched bit no longer active (IF cleared by write or IE cleared): O_INT_REQ=0, go IDLE, no IF change (cancel).
    - Ack wins over cancel in the same cycle.
  - I_INT_ACK in IDLE is ignored.
- Latency: source rises before edge k → IF bit set at edge k → O_INT_REQ high after edge k+1.
- O_INT_VECTOR keeps its last value in IDLE.
- O_INT_PENDING is registered; same latency as O_INT_REQ.
- Reset mid-REQ aborts immediately; no IF clear is performed.

Optional Feature:
- INTC_PENDING_OUT_EN defined: O_INT_PENDING behaves as above.
- Not defined: O_INT_PENDING is tied 0 and its register is omitted. The port list is unchanged either way.

Decomposition:
- Package gb_int_pkg holds:
  - IF_ADDR=16'hFF0F and IE_ADDR=16'hFFFF;
  - source bit indices (VBLANK=0 … JOYPAD=4) and NUM_SRC;
  - the FSM state enum {IDLE, REQ}.
- Sub-module int_priority_enc: 5-bit active mask → 3-bit index + valid, pure combinational. It is instantiated once.

Test Plan:
- Reset, then read 0xFF0F and 0xFFFF → 8'hE0 and 8'h00. IO_DATA is high-Z with I_RE_L=1.
- IE=8'h04, IME=1, pulse I_TIMER_INT.
  - O_INT_REQ=1 two edges after the rise, vector 16'h0050.
  - Ack one cycle → REQ drops next cycle; read 0xFF0F = 8'hE0.
- IE=8'h1F, raise VBLANK and JOYPAD in the same cycle.
  - Vector 16'h0040; after ack, vector 16'h0060; after second ack, IF=0.
- In REQ for the timer (vector 16'h0050), raise VBLANK.
  - Vector stays 16'h0050 until ack, then 16'h0040 is presented next.
- Write 0xFF0F=8'h00 in the same cycle as a timer rising edge → IF[2]=1 (edge wins).
- In REQ, drop I_IME → O_INT_REQ=0 next cycle and IF unchanged.
  - With INTC_PENDING_OUT_EN defined, O_INT_PENDING stays 1.
